// File: rtl/controllo_contatore.sv
// Purpose: push-button front end for the 4-bit up/down counter. It synchronises and
//          debounces up/down/hold, and drives a 4-state control FSM.
// Latency: a raw press reaches the registered outputs DEBOUNCE_CYCLES+3 edges after it rises.
// Backpressure: none. The buttons are free-running levels and the outputs are plain levels.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-low reset
//   btn_up    raw up button (async, active-high)
//   btn_down  raw down button (async, active-high)
//   btn_hold  raw pause/resume button (async, active-high)
//   enable    count enable to the counter (registered)
//   up_down   count direction, 1 = up, 0 = down (registered)
//   state     FSM state code: IDLE=00, UP=01, DOWN=10, PAUSED=11
module controllo_contatore #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_hold,
  output logic       enable,
  output logic       up_down,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_UP     = 2'b01,
    ST_DOWN   = 2'b10,
    ST_PAUSED = 2'b11
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  // Button lanes are packed as bit 0 = up, bit 1 = down, bit 2 = hold.
  logic [2:0]  btn_raw;
  logic [2:0]  s1;
  logic [2:0]  s2;
  logic [2:0]  db;
  logic [2:0]  db_d;
  logic [15:0] cnt [3];
  logic [2:0]  press;

  state_t state_q;
  state_t state_d;
  logic   enable_d;
  logic   up_down_d;

  assign btn_raw = {btn_hold, btn_down, btn_up};

  // Synchroniser, debounce filter and edge register for all three lanes.
  // Any cycle where s2 agrees with db clears cnt, so chatter restarts the window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1   <= '0;
      s2   <= '0;
      db   <= '0;
      db_d <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1   <= btn_raw;
      s2   <= s1;
      db_d <= db;
      for (int i = 0; i < 3; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 16'd1;
        end
      end
    end
  end

  // A press is the rising edge of the debounced level. A release gives no event.
  assign press = db & ~db_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      enable  <= 1'b0;
      up_down <= 1'b1;
    end else begin
      state_q <= state_d;
      enable  <= enable_d;
      up_down <= up_down_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    enable_d  = enable;
    up_down_d = up_down;

    // Hold outranks up/down. When up and down coincide, both are dropped.
    if (press[2]) begin
      case (state_q)
        ST_UP, ST_DOWN: state_d = ST_PAUSED;
        ST_PAUSED:      state_d = up_down ? ST_UP : ST_DOWN;
        default:        state_d = state_q;
      endcase
    end else if (press[0] && press[1]) begin
      state_d = state_q;
    end else if (press[0]) begin
      state_d = ST_UP;
    end else if (press[1]) begin
      state_d = ST_DOWN;
    end

    // The outputs follow the next state. IDLE and PAUSED keep the last direction.
    case (state_d)
      ST_UP: begin
        enable_d  = 1'b1;
        up_down_d = 1'b1;
      end
      ST_DOWN: begin
        enable_d  = 1'b1;
        up_down_d = 1'b0;
      end
      default: begin
        enable_d  = 1'b0;
      end
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_controllo_contatore.sv
module tb_controllo_contatore;

  localparam int D = 4;

  logic       clk;
  logic       reset;
  logic       btn_up;
  logic       btn_down;
  logic       btn_hold;
  logic       enable;
  logic       up_down;
  logic [1:0] state;
  logic [3:0] obs;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Observed outputs packed as {state, enable, up_down}.
  assign obs = {state, enable, up_down};

  controllo_contatore #(.DEBOUNCE_CYCLES(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_hold (btn_hold),
    .enable   (enable),
    .up_down  (up_down),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [3:0] O_IDLE   = 4'b0001;
  localparam logic [3:0] O_UP     = 4'b0111;
  localparam logic [3:0] O_DOWN   = 4'b1010;
  localparam logic [3:0] O_PAUSED = 4'b1100;

  // Drive a button mask (bit0 up, bit1 down, bit2 hold) for len cycles, then release and settle.
  task automatic press(input logic [2:0] mask, input int len);
    @(negedge clk);
    {btn_hold, btn_down, btn_up} = mask;
    repeat (len) @(negedge clk);
    {btn_hold, btn_down, btn_up} = 3'b000;
    repeat (14) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    {btn_hold, btn_down, btn_up} = 3'b000;
    @(negedge clk);
    chk_cnt++;
    if (obs !== O_IDLE) $display("FAIL reset_state: got %b want %b", obs, O_IDLE); else pass_cnt++;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (obs !== O_IDLE) $display("FAIL idle_after_release: got %b want %b", obs, O_IDLE); else pass_cnt++;
  endtask

  task automatic test_hold_in_idle();
    press(3'b100, 8);
    chk_cnt++;
    if (obs !== O_IDLE) $display("FAIL hold_in_idle: got %b want %b", obs, O_IDLE); else pass_cnt++;
  endtask

  task automatic test_up_press();
    @(negedge clk);
    btn_up = 1'b1;
    repeat (6) @(negedge clk);
    chk_cnt++;
    if (obs !== O_IDLE) $display("FAIL up_edge6_early: got %b want %b", obs, O_IDLE); else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (obs !== O_UP) $display("FAIL up_edge7: got %b want %b", obs, O_UP); else pass_cnt++;
    repeat (5) @(negedge clk);
    btn_up = 1'b0;
    repeat (14) @(negedge clk);
    chk_cnt++;
    if (obs !== O_UP) $display("FAIL up_release_no_change: got %b want %b", obs, O_UP); else pass_cnt++;
  endtask

  task automatic test_glitch();
    press(3'b010, D - 1);
    chk_cnt++;
    if (obs !== O_UP) $display("FAIL glitch_rejected: got %b want %b", obs, O_UP); else pass_cnt++;
    @(negedge clk);
    btn_down = 1'b1;
    repeat (D) @(negedge clk);
    btn_down = 1'b0;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if (obs !== O_UP) $display("FAIL down_edge6_early: got %b want %b", obs, O_UP); else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (obs !== O_DOWN) $display("FAIL down_edge7: got %b want %b", obs, O_DOWN); else pass_cnt++;
    repeat (14) @(negedge clk);
  endtask

  task automatic test_pause_resume();
    press(3'b100, 6);
    chk_cnt++;
    if (obs !== O_PAUSED) $display("FAIL pause_from_down: got %b want %b", obs, O_PAUSED); else pass_cnt++;
    press(3'b100, 6);
    chk_cnt++;
    if (obs !== O_DOWN) $display("FAIL resume_down: got %b want %b", obs, O_DOWN); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    press(3'b001, 6);
    chk_cnt++;
    if (obs !== O_UP) $display("FAIL setup_up: got %b want %b", obs, O_UP); else pass_cnt++;
    press(3'b011, 6);
    chk_cnt++;
    if (obs !== O_UP) $display("FAIL up_down_together: got %b want %b", obs, O_UP); else pass_cnt++;
    press(3'b010, 6);
    press(3'b101, 6);
    chk_cnt++;
    if (obs !== O_PAUSED) $display("FAIL hold_up_together: got %b want %b", obs, O_PAUSED); else pass_cnt++;
    press(3'b100, 6);
    chk_cnt++;
    if (obs !== O_DOWN) $display("FAIL resume_after_combo: got %b want %b", obs, O_DOWN); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk_cnt++;
    if (obs !== O_IDLE) $display("FAIL async_reset: got %b want %b", obs, O_IDLE); else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_debounce();
    @(negedge clk);
    btn_up = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    chk_cnt++;
    if (obs !== O_IDLE) $display("FAIL mid_debounce_reset: got %b want %b", obs, O_IDLE); else pass_cnt++;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    chk_cnt++;
    if (obs !== O_IDLE) $display("FAIL rearm_edge6_early: got %b want %b", obs, O_IDLE); else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (obs !== O_UP) $display("FAIL rearm_edge7: got %b want %b", obs, O_UP); else pass_cnt++;
    btn_up = 1'b0;
    repeat (14) @(negedge clk);
  endtask

  // Random press sets checked against a rule-level model. A press registers
  // only if it lasts at least D cycles. All buttons in the set rise together,
  // so their events coincide.
  task automatic test_random();
    int m_state;   // 0 idle, 1 up, 2 down, 3 paused
    int m_en;
    int m_ud;
    logic [2:0] mask;
    int len;
    logic [3:0] exp;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_state = 0; m_en = 0; m_ud = 1;
    for (int n = 0; n < 30; n++) begin
      mask = 3'($urandom_range(1, 7));
      len  = int'($urandom_range(1, 8));
      press(mask, len);
      if (len >= D) begin
        if (mask[2]) begin
          if (m_state == 1 || m_state == 2) m_state = 3;
          else if (m_state == 3) m_state = (m_ud == 1) ? 1 : 2;
        end else if (mask[0] && mask[1]) begin
          m_state = m_state;
        end else if (mask[0]) begin
          m_state = 1;
        end else if (mask[1]) begin
          m_state = 2;
        end
        m_en = (m_state == 1 || m_state == 2) ? 1 : 0;
        if (m_state == 1) m_ud = 1;
        if (m_state == 2) m_ud = 0;
      end
      exp = {2'(m_state), 1'(m_en), 1'(m_ud)};
      chk_cnt++;
      if (obs !== exp)
        $display("FAIL random_%0d mask=%b len=%0d: got %b want %b", n, mask, len, obs, exp);
      else
        pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_hold_in_idle();
    test_up_press();
    test_glitch();
    test_pause_resume();
    test_simultaneous();
    test_async_reset();
    test_reset_mid_debounce();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
